// File: rtl/ram_master.sv
// ram_master: bus-side initiator for a 16x8 synchronous RAM.
// Converts valid/ready requests (single writes, single or burst reads with
// address wrap-around) into one-cycle RAM wr/rd strobes. Read beats are
// returned on a response channel that honours rsp_ready backpressure.
module ram_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // request channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_len,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  // status
  output logic              busy,
  // RAM side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RD_ISSUE = 2'd2,
    RD_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] beats_left_q, beats_left_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // The RAM address and write data come straight from the working registers,
  // so they naturally hold their last value while idle.
  assign mem_addr  = cur_addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

  // State and working registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      wdata_q      <= wdata_d;
    end
  end

  // Next-state logic and per-state outputs (strobes, handshakes, response).
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    wdata_d      = wdata_q;
    req_ready    = 1'b0;
    mem_wr       = 1'b0;
    mem_rd       = 1'b0;
    rsp_valid    = 1'b0;
    rsp_last     = 1'b0;
    rsp_data     = '0;

    case (state_q)
      IDLE: begin
        // Ready is withheld while reset is asserted so nothing is accepted
        // on the reset edge itself.
        req_ready = rst_n;
        if (req_valid && rst_n) begin
          cur_addr_d = req_addr;
          if (req_write) begin
            wdata_d = req_wdata;
            state_d = WRITE;
          end else begin
            beats_left_d = req_len;
            state_d      = RD_ISSUE;
          end
        end
      end

      WRITE: begin
        mem_wr  = 1'b1;
        state_d = IDLE;
      end

      RD_ISSUE: begin
        mem_rd  = 1'b1;
        state_d = RD_RESP;
      end

      RD_RESP: begin
        // The RAM output register holds until the next rd, so passing it
        // through keeps rsp_data stable for as long as the consumer stalls.
        rsp_valid = 1'b1;
        rsp_data  = mem_rdata;
        rsp_last  = (beats_left_q == '0);
        if (rsp_ready) begin
          if (beats_left_q == '0) begin
            state_d = IDLE;
          end else begin
            cur_addr_d   = cur_addr_q + ADDR_W'(1);  // wraps 15 -> 0
            beats_left_d = beats_left_q - ADDR_W'(1);
            state_d      = RD_ISSUE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/ram_master.md
Name: ram_master

Overview:
- Bus-side initiator for the 16x8 synchronous RAM. It turns CPU/loader requests into RAM wr/rd strobes.
- Requests use a valid/ready handshake: single writes, plus single or burst reads with 4-bit address wrap-around.
- Returns read data on a response channel that supports backpressure (rsp_ready).
- Sits between the CPU datapath and the RAM; it is the only driver of the RAM's addr/data_in/wr/rd pins.

Parameters:
ADDR_W, 4, RAM address width; depth = 2**ADDR_W = 16
DATA_W, 8, RAM data width

Ports:
clk  in  1  rising-edge clock, shared with RAM
rst_n  in  1  synchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  block can accept request
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  start address
req_wdata  in  DATA_W  write data (writes only)
req_len  in  ADDR_W  read beats minus 1 (0..15); ignored for writes
rsp_valid  out  1  read beat available
rsp_ready  in  1  consumer accepts beat
rsp_data  out  DATA_W  read beat data; 0 when rsp_valid=0
rsp_last  out  1  final beat of burst; only meaningful with rsp_valid
busy  out  1  state != IDLE
mem_addr  out  ADDR_W  to RAM addr
mem_wdata  out  DATA_W  to RAM data_in
mem_wr  out  1  to RAM wr
mem_rd  out  1  to RAM rd
mem_rdata  in  DATA_W  from RAM data_out (RAM registers it; it holds until next rd)

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; mem_wr=0, mem_rd=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_last=0, busy=0. req_ready is forced 0 while rst_n=0. RAM contents are untouched.
- Reset mid-operation aborts immediately. No further mem strobes or beats; rsp_valid=0 from the cycle after the reset edge.
- States: IDLE, WRITE, RD_ISSUE, RD_RESP. req_ready = (state==IDLE) && rst_n.
- Accept = req_valid && req_ready at an edge. Latch addr, wdata and len into cur_addr, wdata_q and beats_left.
- IDLE -> WRITE on accepted write. IDLE -> RD_ISSUE on accepted read.
- WRITE (exactly 1 cycle): mem_wr=1, mem_rd=0, mem_addr=cur_addr, mem_wdata=wdata_q. Next state IDLE. No write response.
- RD_ISSUE (1 cycle): mem_rd=1, mem_wr=0, mem_addr=cur_addr. Next state RD_RESP.
- RD_RESP: mem_rd=0, mem_wr=0. rsp_valid=1; rsp_data=mem_rdata (passed through); rsp_last=(beats_left==0).
  - If rsp_ready and beats_left==0: next state IDLE.
  - If rsp_ready and beats_left>0: cur_addr <= cur_addr+1 mod 16, beats_left <= beats_left-1, next state RD_ISSUE.
  - If !rsp_ready: hold. rsp_data stays stable because no mem_rd is issued.
- Latency: accept edge T -> mem strobe during cycle T+1 -> first rsp_valid in cycle T+2. Burst throughput is 1 beat per 2 cycles with rsp_ready=1.
- Address wrap: 15 -> 0 without error. A burst of len=15 touches all 16 locations once.
- mem_wr and mem_rd are never both 1. Each is high for exactly one cycle per operation.
- mem_addr and mem_wdata hold their last values when idle. Strobes are 0 outside WRITE/RD_ISSUE.
- req_valid while busy: ignored (req_ready=0). The producer must hold the request until accepted.
- Next request is accepted at the earliest in the cycle after return to IDLE. Write-to-write spacing is 2 cycles.

Test Plan:
1. rst_n=0 for 3 cycles with req_valid=1 -> req_ready=0, mem_wr=mem_rd=0, rsp_valid=0, busy=0. After release, req_ready=1 and no stray strobe.
2. Write addr 5 data 0xA5, then read addr 5 len 0 -> one-cycle mem_wr with mem_addr=5, mem_wdata=0xA5. rsp_valid 2 cycles after read accept, with rsp_data=0xA5 and rsp_last=1.
3. Prefill 14,15,0,1 with 0x11,0x22,0x33,0x44; read addr 14 len 3, rsp_ready=1 -> mem_addr sequence 14,15,0,1; beats 0x11,0x22,0x33,0x44; rsp_last only on 4th; busy for 8 cycles.
4. Same burst with rsp_ready=0 for 5 cycles on beat 2 -> rsp_data held at 0x22 and rsp_valid held 1; no mem_rd during the stall; beats 3-4 follow correctly.
5. Assert rst_n=0 after beat 1 of a len=3 burst -> rsp_valid=0 next cycle, no further mem_rd. A subsequent single read of addr 0 returns 0x33.
6. Issue req_valid throughout a burst plus a back-to-back write -> req_ready=0 until IDLE, request accepted once. Assertion checks mem_wr && mem_rd never true.
